pipelined_multiplier_stream: RTL and testbench

PIPELINED_MULTIPLIER_STREAM -- requirements
Module: pipelined_multiplier_stream

---
 rtl/pipelined_multiplier_stream.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_multiplier_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier_stream.sv
// Streaming WIDTHxWIDTH multiplier: free-running LATENCY-stage pipeline into a FWFT result FIFO, credit-gated input.
// Backpressure is absorbed by the FIFO; in_ready is registered state only. Optional sideband tag: MULT_TAG_EN.
module pipelined_multiplier_stream #(
  parameter int WIDTH      = 64,
  parameter int LATENCY    = 18,
  parameter int FIFO_DEPTH = 20,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
`ifdef MULT_TAG_EN
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [TAG_WIDTH-1:0] out_tag,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam bit CFG_OK = (WIDTH >= 2) && (LATENCY >= 1) && (FIFO_DEPTH >= 1) && (TAG_WIDTH >= 1);

  logic                 accept;
  logic                 pop;
  logic [CW-1:0]        credit;
  logic [CW-1:0]        fifo_cnt;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 fifo_wr;
  logic                 fifo_full;
  logic [2*WIDTH-1:0]   fifo_wdat;
  logic [LATENCY-1:0]   vld_pipe;

  // Credits cover every in-flight op plus every buffered result, so the FIFO can never overflow.
  assign in_ready  = !rst && (credit < CW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign fifo_wr   = vld_pipe[LATENCY-1];
  assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit <= '0;
    end else if (accept && !pop) begin
      credit <= credit + CW'(1);
    end else if (pop && !accept) begin
      credit <= credit - CW'(1);
    end
  end

  // Stage 0 holds raw operands; data registers need no reset since the valid bits qualify them.
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic             s0_signed;

  always_ff @(posedge clk) begin
    s0_a      <= in_a;
    s0_b      <= in_b;
    s0_signed <= in_signed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // One extra bit per operand turns the mixed signed/unsigned case into a single signed multiply.
  logic signed [WIDTH:0]     ext_a;
  logic signed [WIDTH:0]     ext_b;
  logic signed [2*WIDTH-1:0] prod_s0;

  assign ext_a   = {s0_signed & s0_a[WIDTH-1], s0_a};
  assign ext_b   = {s0_signed & s0_b[WIDTH-1], s0_b};
  assign prod_s0 = (2*WIDTH)'(ext_a) * (2*WIDTH)'(ext_b);

`ifdef MULT_TAG_EN
  logic [TAG_WIDTH-1:0] s0_tag;
  logic [TAG_WIDTH-1:0] tag_wdat;

  always_ff @(posedge clk) begin
    s0_tag <= in_tag;
  end
`endif

  generate
    if (LATENCY == 1) begin : g_lat1
      assign fifo_wdat = prod_s0;
`ifdef MULT_TAG_EN
      assign tag_wdat  = s0_tag;
`endif
    end else begin : g_latn
      logic [2*WIDTH-1:0] prod_pipe [1:LATENCY-1];

      // Retiming is expected to spread the multiplier across these delay stages.
      always_ff @(posedge clk) begin
        prod_pipe[1] <= prod_s0;
        for (int i = 2; i < LATENCY; i++) begin
          prod_pipe[i] <= prod_pipe[i-1];
        end
      end
      assign fifo_wdat = prod_pipe[LATENCY-1];

`ifdef MULT_TAG_EN
      logic [TAG_WIDTH-1:0] tag_pipe [1:LATENCY-1];

      always_ff @(posedge clk) begin
        tag_pipe[1] <= s0_tag;
        for (int i = 2; i < LATENCY; i++) begin
          tag_pipe[i] <= tag_pipe[i-1];
        end
      end
      assign tag_wdat = tag_pipe[LATENCY-1];
`endif
    end
  endgenerate

  logic [2*WIDTH-1:0] p_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      p_mem[wr_ptr] <= fifo_wdat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (fifo_wr && !pop) begin
        fifo_cnt <= fifo_cnt + CW'(1);
      end else if (pop && !fifo_wr) begin
        fifo_cnt <= fifo_cnt - CW'(1);
      end
    end
  end

  assign out_p = p_mem[rd_ptr];

`ifdef MULT_TAG_EN
  logic [TAG_WIDTH-1:0] tag_mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      tag_mem[wr_ptr] <= tag_wdat;
    end
  end

  // Gated so the tag reads as zero out of reset rather than stale storage.
  assign out_tag = out_valid ? tag_mem[rd_ptr] : '0;
`endif

  assert property (@(posedge clk) disable iff (rst) CFG_OK);
  assert property (@(posedge clk) disable iff (rst) !(fifo_wr && fifo_full));
  assert property (@(posedge clk) disable iff (rst) credit <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_pipelined_multiplier_stream.sv
// Directed bench for pipelined_multiplier_stream: hand-computed products, streaming scoreboard, backpressure and reset cases.
module tb_pipelined_multiplier_stream;

  localparam int W = 64;
  localparam int L = 18;
  localparam int D = 20;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
`ifdef MULT_TAG_EN
  logic [7:0]     in_tag;
  logic [7:0]     out_tag;
  logic [7:0]     tag_q [$];
  logic [7:0]     held_tag;
  int             tag_pops;
`endif

  pipelined_multiplier_stream #(
    .WIDTH(W), .LATENCY(L), .FIFO_DEPTH(D), .TAG_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
`ifdef MULT_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Scoreboard: records accepts, checks pops in order, checks hold stability under backpressure.
  logic           mon_en = 1'b0;
  logic [2*W-1:0] exp_q [$];
  int             pop_cnt;
  int             acc_cnt;
  int             first_pop;
  int             last_pop;
  logic           held_vld = 1'b0;
  logic [2*W-1:0] held_p;

  always @(negedge clk) begin
    if (!rst && held_vld && out_valid) begin
      chk("hold_p", out_p, held_p);
`ifdef MULT_TAG_EN
      chk("hold_tag", {120'd0, out_tag}, {120'd0, held_tag});
`endif
    end
    held_vld = !rst && out_valid && !out_ready;
    held_p   = out_p;
`ifdef MULT_TAG_EN
    held_tag = out_tag;
`endif
    if (mon_en && !rst) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (pop_cnt == 1) first_pop = cyc;
        last_pop = cyc;
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("result", out_p, exp_q.pop_front());
`ifdef MULT_TAG_EN
        tag_pops++;
        if (tag_q.size() != 0) chk("tag", {120'd0, out_tag}, {120'd0, tag_q.pop_front()});
`endif
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        exp_q.push_back(ref_mul(in_a, in_b, in_signed));
`ifdef MULT_TAG_EN
        tag_q.push_back(in_tag);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    in_a      = {$urandom, $urandom};
    in_b      = {$urandom, $urandom};
    in_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int t = 0; t < budget && pop_cnt < n; t++) tick();
  endtask

  // Single op with out_ready high: check latency and hand-computed product.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic [2*W-1:0] exp);
    int lat;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40 && !out_valid) begin
      tick();
      lat++;
    end
    chk("latency", lat, L);
    chk("product", out_p, exp);
    tick();
    chk("drained", out_valid, 0);
  endtask

  logic [W-1:0]   va [8];
  logic [W-1:0]   vb [8];
  logic           vs [8];
  logic [2*W-1:0] vp [8];

  initial begin
    int drops;
    int sent;
    int seen;
    logic ok;

    va[0] = 64'hFFFFFFFFFFFFFFFF; vb[0] = 64'd2;               vs[0] = 1'b0; vp[0] = 128'h0000000000000001FFFFFFFFFFFFFFFE;
    va[1] = 64'hFFFFFFFFFFFFFFFF; vb[1] = 64'd2;               vs[1] = 1'b1; vp[1] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE;
    va[2] = 64'hFFFFFFFFFFFFFFFF; vb[2] = 64'hFFFFFFFFFFFFFFFF; vs[2] = 1'b0; vp[2] = 128'hFFFFFFFFFFFFFFFE0000000000000001;
    va[3] = 64'hFFFFFFFFFFFFFFFF; vb[3] = 64'hFFFFFFFFFFFFFFFF; vs[3] = 1'b1; vp[3] = 128'h00000000000000000000000000000001;
    va[4] = 64'h8000000000000000; vb[4] = 64'h8000000000000000; vs[4] = 1'b1; vp[4] = 128'h40000000000000000000000000000000;
    va[5] = 64'h8000000000000000; vb[5] = 64'd1;               vs[5] = 1'b1; vp[5] = 128'hFFFFFFFFFFFFFFFF8000000000000000;
    va[6] = 64'h0000000000001234; vb[6] = 64'h10;              vs[6] = 1'b0; vp[6] = 128'h00000000000000000000000000012340;
    va[7] = 64'h7FFFFFFFFFFFFFFF; vb[7] = 64'hFFFFFFFFFFFFFFFF; vs[7] = 1'b1; vp[7] = 128'hFFFFFFFFFFFFFFFF8000000000000001;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b0;
    pop_cnt = 0; acc_cnt = 0; first_pop = 0; last_pop = 0;
`ifdef MULT_TAG_EN
    in_tag = '0; tag_pops = 0;
`endif
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed products, first one accepted on the first edge after reset release.
    for (int i = 0; i < 8; i++) run_one(va[i], vb[i], vs[i], vp[i]);

    // Back-to-back random stream.
    mon_en = 1'b1; pop_cnt = 0; drops = 0; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      in_valid = 1'b1;
      if (!in_ready) drops++;
      tick();
    end
    in_valid = 1'b0;
    wait_pops(100, 60);
    chk("b2b_ready_drops", drops, 0);
    chk("b2b_pops", pop_cnt, 100);
    chk("b2b_span", last_pop - first_pop, 99);

    // Full backpressure: exactly D credits.
    out_ready = 1'b0; acc_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      rand_ops();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc_cnt, D);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    pop_cnt = 0; out_ready = 1'b1;
    tick();
    chk("bp_ready_back", in_ready, 1);
    wait_pops(D, 60);
    chk("bp_pops", pop_cnt, D);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Credit boundary at 19 and 20.
    out_ready = 1'b0; sent = 0;
    for (int t = 0; t < 40 && sent < D - 1; t++) begin
      rand_ops();
      in_valid = 1'b1;
      if (in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    repeat (L + 2) tick();
    chk("c19_ready", in_ready, 1);
    rand_ops(); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("c19_both_ready", in_ready, 1);
    rand_ops(); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk("c20_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("c20_pop_ready", in_ready, 1);
    repeat (L + D + 4) tick();
    chk("c_queue_empty", exp_q.size(), 0);

    // Reset with results both buffered and in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_ops(); in_valid = 1'b1; tick(); end
    in_valid = 1'b0;
    repeat (L + 2) tick();
    for (int i = 0; i < 5; i++) begin rand_ops(); in_valid = 1'b1; tick(); end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("pre_rst_out_valid", out_valid, 1);
    mon_en = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    exp_q.delete();
`ifdef MULT_TAG_EN
    tag_q.delete();
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1; seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_ghost_results", seen, 0);
    run_one(va[7], vb[7], vs[7], vp[7]);

`ifdef MULT_TAG_EN
    // Tags 0..7 under random output backpressure.
    mon_en = 1'b1; tag_pops = 0; sent = 0;
    rand_ops();
    for (int t = 0; t < 200 && sent < 8; t++) begin
      in_tag = 8'(sent);
      in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      ok = in_ready;
      tick();
      if (ok) begin sent++; rand_ops(); end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 300 && tag_pops < 8; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("tag_pops", tag_pops, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
